// File: rtl/step_clock_gen_if.sv
// Signal bundle between the stepping-clock generator and its board/debug-side user.
// The slave modport is the generator; the master modport drives the raw inputs.
interface step_clock_gen_if;
  logic        btn_step;
  logic        run_en;
  logic        core_clk;
  logic        busy;
  logic        btn_db;
  logic [31:0] step_count;
  logic        overrun;

  modport master (
    output btn_step,
    output run_en,
    input  core_clk,
    input  busy,
    input  btn_db,
    input  step_count,
    input  overrun
  );

  modport slave (
    input  btn_step,
    input  run_en,
    output core_clk,
    output busy,
    output btn_db,
    output step_count,
    output overrun
  );
endinterface

// File: rtl/step_clock_gen.sv
// Stepping clock for the single-cycle core: one clean pulse per debounced button press,
// or free-running pulses at a divided rate when the run switch is on.
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 5000000,
  parameter int unsigned PULSE_HIGH      = 4,
  parameter int unsigned PULSE_LOW       = 4,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input logic             clk,
  input logic             reset,
  step_clock_gen_if.slave sc
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DivW   = $clog2(RUN_DIV + 1);
  localparam int unsigned PhMax  = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int unsigned PhW    = $clog2(PhMax + 1);

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(RUN_DIV - 1);
  localparam logic [PhW-1:0]  HighLast = PhW'(PULSE_HIGH - 1);
  localparam logic [PhW-1:0]  LowLast  = PhW'(PULSE_LOW - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  logic            btn_meta_q, btn_sync_q, run_meta_q, run_sync_q;
  logic            btn_lvl;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d, btn_db_dly_q;
  logic            press_q, press_d;
  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic            req;
  state_e          state_q, state_d;
  logic [PhW-1:0]  ph_cnt_q, ph_cnt_d;
  logic            core_clk_q, core_clk_d;
  logic            busy_q, busy_d;
  logic [31:0]     step_count_q, step_count_d;
  logic            overrun_q, overrun_d;

  // Synchronizer flops reset to the raw not-pressed level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= BTN_ACTIVE_LOW;
      btn_sync_q <= BTN_ACTIVE_LOW;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      btn_meta_q <= sc.btn_step;
      btn_sync_q <= btn_meta_q;
      run_meta_q <= sc.run_en;
      run_sync_q <= run_meta_q;
    end
  end

  assign btn_lvl = btn_sync_q ^ BTN_ACTIVE_LOW;

  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_lvl != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = btn_lvl;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press_d = btn_db_q & ~btn_db_dly_q;

  always_comb begin
    div_d  = '0;
    tick_d = 1'b0;
    if (run_sync_q) begin
      if (div_q == DivLast) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  assign req = run_sync_q ? tick_q : press_q;

  always_comb begin
    state_d      = state_q;
    ph_cnt_d     = ph_cnt_q;
    core_clk_d   = core_clk_q;
    step_count_d = step_count_q;
    overrun_d    = overrun_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d      = StHigh;
          ph_cnt_d     = '0;
          core_clk_d   = 1'b1;
          step_count_d = step_count_q + 32'd1;
        end
      end
      StHigh: begin
        overrun_d = overrun_q | req;
        if (ph_cnt_q == HighLast) begin
          state_d    = StLow;
          ph_cnt_d   = '0;
          core_clk_d = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      StLow: begin
        // Also covers a request on the LOW->IDLE cycle: it is dropped.
        overrun_d = overrun_q | req;
        if (ph_cnt_q == LowLast) begin
          state_d  = StIdle;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        ph_cnt_d   = '0;
        core_clk_d = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q     <= '0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      press_q      <= 1'b0;
      div_q        <= '0;
      tick_q       <= 1'b0;
      state_q      <= StIdle;
      ph_cnt_q     <= '0;
      core_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_q;
      press_q      <= press_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      ph_cnt_q     <= ph_cnt_d;
      core_clk_q   <= core_clk_d;
      busy_q       <= busy_d;
      step_count_q <= step_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sc.core_clk   = core_clk_q;
  assign sc.busy       = busy_q;
  assign sc.btn_db     = btn_db_q;
  assign sc.step_count = step_count_q;
  assign sc.overrun    = overrun_q;

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
Generates the processor's stepping clock `core_clk` from the 50 MHz board clock. It feeds the `clk` input of the single-cycle RV32I core.
- Step mode: each debounced press of a raw push-button yields exactly one clean core clock pulse.
- Run mode: a slide switch selects free-running pulses at a divided rate.
- A step counter, busy flag and overrun flag are exported for the VGA debug display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable board-clock cycles required to accept a button level change (min 2)
RUN_DIV, 5000000, board-clock cycles between run-mode pulse requests (min 2)
PULSE_HIGH, 4, board-clock cycles core_clk stays high per pulse (min 1)
PULSE_LOW, 4, minimum board-clock cycles core_clk stays low after a pulse before the next request is accepted (min 1)
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed

Ports:
clk  input  1  board clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
btn_step  input  1  raw, asynchronous push-button
run_en  input  1  raw, asynchronous mode switch; 1 = run, 0 = step
core_clk  output  1  registered stepping clock to the core
busy  output  1  1 while pulse FSM is not IDLE
btn_db  output  1  debounced button level, 1 = pressed (LED)
step_count  output  32  number of core_clk rising edges since reset
overrun  output  1  sticky: a pulse request arrived while busy

Behaviour:
- Reset (async, active-high) takes effect immediately, including mid-pulse. Reset values:
  - core_clk=0, busy=0, btn_db=0, step_count=0, overrun=0.
  - Synchronizer flops = not-pressed / 0; debounce counter=0; divider=0; FSM=IDLE.
- Input conditioning:
  - btn_step and run_en each pass through a 2-flop synchronizer.
  - Button polarity is normalized per BTN_ACTIVE_LOW, so pressed = 1 internally.
- Debounce:
  - While synchronized level != btn_db, the counter increments each clock.
  - While synchronized level == btn_db, the counter clears.
  - When the counter would reach DEBOUNCE_CYCLES, btn_db takes the new level and the counter clears.
  - Any bounce before that restarts the count.
- Press event: a registered one-cycle pulse, asserted the cycle after btn_db goes 0->1. Release (1->0) generates no event.
- Run divider:
  - Counts only while synchronized run_en=1; it clears whenever synchronized run_en=0.
  - It issues a one-cycle tick when count = RUN_DIV-1, then wraps to 0.
  - The first tick occurs RUN_DIV clocks after synchronized run_en rises.
- Request source:
  - run_en=1: request = tick; press events are ignored.
  - run_en=0: request = press event.
- Pulse FSM:
  - IDLE: on request -> HIGH. At that same edge core_clk<=1 and step_count<=step_count+1 (wraps 0xFFFFFFFF->0).
  - HIGH: core_clk=1 for exactly PULSE_HIGH cycles -> LOW.
  - LOW: core_clk=0 for exactly PULSE_LOW cycles -> IDLE.
  - A request arriving in HIGH or LOW is dropped and sets overrun (sticky until reset).
  - A request and the LOW->IDLE transition on the same cycle: the request is dropped and overrun is set.
- busy=1 in HIGH and LOW, 0 in IDLE; it is registered, aligned with the state.
- Latency, step mode: first edge sampling a stable press is edge 1. btn_db rises at edge DEBOUNCE_CYCLES+2, the press event at edge DEBOUNCE_CYCLES+3, and core_clk rises at edge DEBOUNCE_CYCLES+4.
- Holding the button generates exactly one pulse. A new pulse requires a debounced release and then a debounced press.
- Switching mode mid-pulse does not truncate the pulse in progress.
- core_clk is glitch-free (driven directly from a flop). Only one core rising edge occurs per request.

Test Plan:
(bench params: DEBOUNCE_CYCLES=4, RUN_DIV=8, PULSE_HIGH=2, PULSE_LOW=2, BTN_ACTIVE_LOW=1)
1. Clean press: btn_step 1->0 held 30 cycles -> core_clk high exactly 2 cycles starting edge 8; step_count 0->1; busy high 4 cycles; no second pulse while held.
2. Bounce/glitch:
   - btn_step toggles every 2 cycles for 12 cycles, then stays low -> exactly one pulse, step_count=1.
   - A separate 3-cycle low glitch -> btn_db stays 0, no pulse.
3. Release: after scenario 1, release the button and hold it released 20 cycles -> no pulse. A second clean press -> step_count=2.
4. Run mode:
   - run_en=1 for 82 cycles after synchronization -> 10 pulses, rising edges 8 cycles apart, step_count=10, overrun=0.
   - Button presses during run mode are ignored.
5. Reset mid-pulse: assert reset while core_clk=1 -> core_clk, busy, step_count, overrun all 0 before the next clk edge. After release, a press yields normal latency.
6. Overrun: RUN_DIV=3 with PULSE_HIGH+PULSE_LOW=4, run_en=1 -> overrun=1 after the second tick; pulses stay 2 high / 2 low. Wrap check: force step_count=0xFFFFFFFF, one pulse -> 0.
